// File: rtl/cond_flags_stage_if.sv
// rtl/cond_flags_stage_if.sv - Handshake and payload bundle for the condition/flags stage.
// Signal names follow the stage's point of view: i_* flow into the stage, o_* flow out.
interface cond_flags_stage_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_result;
  logic [3:0]  i_nzcv;
  logic        i_set_flags;
  logic [3:0]  i_cond;
  logic [3:0]  i_rd;
  logic        i_wr_en;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [3:0]  o_rd;
  logic        o_wr_en;
  logic        o_cond_pass;
  logic [3:0]  o_flags;

  modport slave (
    input  i_valid, i_result, i_nzcv, i_set_flags, i_cond, i_rd, i_wr_en, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_rd, o_wr_en, o_cond_pass, o_flags
  );

  modport master (
    output i_valid, i_result, i_nzcv, i_set_flags, i_cond, i_rd, i_wr_en, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_rd, o_wr_en, o_cond_pass, o_flags
  );
endinterface

// File: rtl/cond_flags_stage.sv
// rtl/cond_flags_stage.sv - ARM condition evaluation, NZCV flags register and output buffer.
// STAGE_SKID_EN selects a DEPTH-entry FIFO with registered ready; otherwise a single register.
module cond_flags_stage #(
  parameter int DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  cond_flags_stage_if.slave  s
);

`ifdef STAGE_SKID_EN
  localparam int DEPTH_I = (DEPTH < 1) ? 1 : DEPTH;
`else
  // Single-register mode always holds exactly one entry whatever DEPTH says.
  localparam int DEPTH_I = (DEPTH < 1) ? 1 : 1;
`endif
  localparam int PW    = (DEPTH_I > 1) ? $clog2(DEPTH_I) : 1;
  localparam int SLOTS = 1 << PW;
  localparam int CW    = $clog2(DEPTH_I + 1);

  logic [31:0]   r_result [SLOTS];
  logic [3:0]    r_rd     [SLOTS];
  logic          r_wr_en  [SLOTS];
  logic          r_pass   [SLOTS];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [3:0]    r_flags;

  logic w_valid;
  logic w_ready;
  logic w_accept;
  logic w_drain;
  logic w_pass;

  function automatic logic f_cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, res;
    {n, z, c, v} = f;
    case (cond)
      4'h0:    res = z;
      4'h1:    res = !z;
      4'h2:    res = c;
      4'h3:    res = !c;
      4'h4:    res = n;
      4'h5:    res = !n;
      4'h6:    res = v;
      4'h7:    res = !v;
      4'h8:    res = c && !z;
      4'h9:    res = !c || z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = !z && (n == v);
      4'hD:    res = z || (n != v);
      4'hE:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH_I - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_valid = (r_count != '0);
  assign w_pass  = f_cond_pass(s.i_cond, r_flags);

`ifdef STAGE_SKID_EN
  // Ready depends only on registered occupancy, never on downstream i_ready.
  assign w_ready = i_rst_n && !s.i_flush && (r_count != CW'(DEPTH_I));
`else
  assign w_ready = i_rst_n && !s.i_flush && (!w_valid || s.i_ready);
`endif

  assign w_accept = s.i_valid && w_ready;
  assign w_drain  = w_valid && s.i_ready && !s.i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_result[i] <= '0;
        r_rd[i]     <= '0;
        r_wr_en[i]  <= 1'b0;
        r_pass[i]   <= 1'b0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_flags <= '0;
    end else if (s.i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_result[r_tail] <= s.i_result;
        r_rd[r_tail]     <= s.i_rd;
        r_wr_en[r_tail]  <= s.i_wr_en && w_pass;
        r_pass[r_tail]   <= w_pass;
        r_tail           <= f_next(r_tail);
        // Updating here lets the very next accepted instruction see the new flags.
        if (w_pass && s.i_set_flags) begin
          r_flags <= s.i_nzcv;
        end
      end
      if (w_drain) begin
        r_head <= f_next(r_head);
      end
      case ({w_accept, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign s.o_ready = w_ready;
  assign s.o_valid = w_valid;
  assign s.o_flags = r_flags;

  always_comb begin
    s.o_result    = '0;
    s.o_rd        = '0;
    s.o_wr_en     = 1'b0;
    s.o_cond_pass = 1'b0;
    if (w_valid) begin
      s.o_result    = r_result[r_head];
      s.o_rd        = r_rd[r_head];
      s.o_wr_en     = r_wr_en[r_head];
      s.o_cond_pass = r_pass[r_head];
    end
  end

endmodule

// File: tb/tb_cond_flags_stage.sv
// tb/tb_cond_flags_stage.sv - Directed self-checking bench for cond_flags_stage.
module tb_cond_flags_stage;

`ifdef STAGE_SKID_EN
  localparam bit SKID = 1'b1;
  localparam int CAP  = 2;
`else
  localparam bit SKID = 1'b0;
  localparam int CAP  = 1;
`endif

  localparam logic [3:0] EQ = 4'h0, NE = 4'h1, CS = 4'h2, GE = 4'hA, LT = 4'hB;
  localparam logic [3:0] GT = 4'hC, LE = 4'hD, HI = 4'h8, LS = 4'h9, MI = 4'h4, PL = 4'h5;
  localparam logic [3:0] AL = 4'hE, NV = 4'hF;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  cond_flags_stage_if bus();

  cond_flags_stage #(.DEPTH(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .s       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] nzcv,
                       input logic sf, input logic [3:0] cond, input logic [3:0] rd,
                       input logic wr);
    bus.i_valid     = v;
    bus.i_result    = res;
    bus.i_nzcv      = nzcv;
    bus.i_set_flags = sf;
    bus.i_cond      = cond;
    bus.i_rd        = rd;
    bus.i_wr_en     = wr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0, AL, 4'h0, 1'b0);
    bus.i_ready = 1'b1;
    bus.i_flush = 1'b0;
    #1;
    if (bus.o_valid !== 1'b0) begin $display("FAIL rst_valid got=%0b exp=0", bus.o_valid); n_bad++; end n_cmp++;
    if (bus.o_ready !== 1'b0) begin $display("FAIL rst_ready got=%0b exp=0", bus.o_ready); n_bad++; end n_cmp++;
    if (bus.o_flags !== 4'h0) begin $display("FAIL rst_flags got=%h exp=0", bus.o_flags); n_bad++; end n_cmp++;
    if (bus.o_result !== 32'h0) begin $display("FAIL rst_result got=%h exp=0", bus.o_result); n_bad++; end n_cmp++;
    step();
    step();
    rst_n = 1'b1;
    #1;
    if (bus.o_ready !== 1'b1) begin $display("FAIL rst_release_ready got=%0b exp=1", bus.o_ready); n_bad++; end n_cmp++;
    if (bus.o_valid !== 1'b0) begin $display("FAIL rst_release_valid got=%0b exp=0", bus.o_valid); n_bad++; end n_cmp++;
  endtask

  task automatic test_basic();
    drive(1'b1, 32'h0, 4'b0100, 1'b1, AL, 4'h3, 1'b1);
    step();
    if (bus.o_valid !== 1'b1) begin $display("FAIL basic_valid got=%0b exp=1", bus.o_valid); n_bad++; end n_cmp++;
    if (bus.o_cond_pass !== 1'b1) begin $display("FAIL basic_pass got=%0b exp=1", bus.o_cond_pass); n_bad++; end n_cmp++;
    if (bus.o_flags !== 4'b0100) begin $display("FAIL basic_flags got=%b exp=0100", bus.o_flags); n_bad++; end n_cmp++;
    if (bus.o_wr_en !== 1'b1) begin $display("FAIL basic_wr_en got=%0b exp=1", bus.o_wr_en); n_bad++; end n_cmp++;
    if (bus.o_rd !== 4'h3) begin $display("FAIL basic_rd got=%h exp=3", bus.o_rd); n_bad++; end n_cmp++;
    drive(1'b0, 32'h0, 4'h0, 1'b0, AL, 4'h0, 1'b0);
    step();
    if (bus.o_valid !== 1'b0) begin $display("FAIL basic_drained got=%0b exp=0", bus.o_valid); n_bad++; end n_cmp++;
    if (bus.o_rd !== 4'h0) begin $display("FAIL basic_idle_rd got=%h exp=0", bus.o_rd); n_bad++; end n_cmp++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'hA1, 4'h0, 1'b0, EQ, 4'h1, 1'b1);
    step();
    if (bus.o_result !== 32'hA1) begin $display("FAIL b2b_eq_result got=%h exp=a1", bus.o_result); n_bad++; end n_cmp++;
    if (bus.o_wr_en !== 1'b1) begin $display("FAIL b2b_eq_wr_en got=%0b exp=1", bus.o_wr_en); n_bad++; end n_cmp++;
    drive(1'b1, 32'hB2, 4'h0, 1'b0, NE, 4'h2, 1'b1);
    step();
    if (bus.o_valid !== 1'b1) begin $display("FAIL b2b_ne_valid got=%0b exp=1", bus.o_valid); n_bad++; end n_cmp++;
    if (bus.o_result !== 32'hB2) begin $display("FAIL b2b_ne_result got=%h exp=b2", bus.o_result); n_bad++; end n_cmp++;
    if (bus.o_wr_en !== 1'b0) begin $display("FAIL b2b_ne_wr_en got=%0b exp=0", bus.o_wr_en); n_bad++; end n_cmp++;
    if (bus.o_cond_pass !== 1'b0) begin $display("FAIL b2b_ne_pass got=%0b exp=0", bus.o_cond_pass); n_bad++; end n_cmp++;
    if (bus.o_rd !== 4'h2) begin $display("FAIL b2b_ne_rd got=%h exp=2", bus.o_rd); n_bad++; end n_cmp++;
    drive(1'b1, 32'hC3, 4'b0010, 1'b1, AL, 4'h3, 1'b1);
    step();
    if (bus.o_flags !== 4'b0010) begin $display("FAIL fwd_flags got=%b exp=0010", bus.o_flags); n_bad++; end n_cmp++;
    drive(1'b1, 32'hD4, 4'h0, 1'b0, CS, 4'h4, 1'b1);
    step();
    if (bus.o_cond_pass !== 1'b1) begin $display("FAIL fwd_cs_pass got=%0b exp=1", bus.o_cond_pass); n_bad++; end n_cmp++;
    drive(1'b1, 32'hE5, 4'h0, 1'b0, EQ, 4'h5, 1'b1);
    step();
    if (bus.o_cond_pass !== 1'b0) begin $display("FAIL fwd_eq_pass got=%0b exp=0", bus.o_cond_pass); n_bad++; end n_cmp++;
    drive(1'b0, 32'h0, 4'h0, 1'b0, AL, 4'h0, 1'b0);
    step();
  endtask

  task automatic test_conditions();
    logic [3:0] conds [8];
    logic       exps  [8];
    conds = '{GE, LT, GT, LE, HI, LS, MI, PL};
    exps  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    drive(1'b1, 32'h1, 4'b1001, 1'b1, AL, 4'h7, 1'b0);
    step();
    if (bus.o_flags !== 4'b1001) begin $display("FAIL cond_setup_flags got=%b exp=1001", bus.o_flags); n_bad++; end n_cmp++;
    drive(1'b1, 32'h2, 4'b1111, 1'b1, NV, 4'h7, 1'b1);
    step();
    if (bus.o_flags !== 4'b1001) begin $display("FAIL nv_flags got=%b exp=1001", bus.o_flags); n_bad++; end n_cmp++;
    if (bus.o_wr_en !== 1'b0) begin $display("FAIL nv_wr_en got=%0b exp=0", bus.o_wr_en); n_bad++; end n_cmp++;
    if (bus.o_valid !== 1'b1) begin $display("FAIL nv_valid got=%0b exp=1", bus.o_valid); n_bad++; end n_cmp++;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + i, 4'h0, 1'b0, conds[i], 4'h8, 1'b1);
      step();
      if (bus.o_cond_pass !== exps[i]) begin $display("FAIL cond_%h_pass got=%0b exp=%0b", conds[i], bus.o_cond_pass, exps[i]); n_bad++; end n_cmp++;
      if (bus.o_wr_en !== exps[i]) begin $display("FAIL cond_%h_wr_en got=%0b exp=%0b", conds[i], bus.o_wr_en, exps[i]); n_bad++; end n_cmp++;
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0, AL, 4'h0, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] offers [3];
    logic [31:0] q [$];
    int          occ;
    int          idx;
    int          got;
    logic        rdy_in;
    logic        exp_rdy;
    offers = '{32'h11, 32'h22, 32'h33};
    occ = 0;
    idx = 0;
    got = 0;
    rdy_in = 1'b0;
    bus.i_ready = rdy_in;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, offers[idx], 4'h0, 1'b0, AL, 4'h9, 1'b1);
      #1;
      exp_rdy = SKID ? (occ < CAP) : (occ == 0 || rdy_in);
      if (bus.o_ready !== exp_rdy) begin $display("FAIL bp_fill_ready c=%0d got=%0b exp=%0b", c, bus.o_ready, exp_rdy); n_bad++; end n_cmp++;
      if (exp_rdy) begin
        q.push_back(offers[idx]);
        idx++;
        occ++;
      end
      step();
    end
    rdy_in = 1'b1;
    bus.i_ready = rdy_in;
    for (int c = 0; c < 12 && got < 3; c++) begin
      if (idx < 3) drive(1'b1, offers[idx], 4'h0, 1'b0, AL, 4'h9, 1'b1);
      else         drive(1'b0, 32'h0, 4'h0, 1'b0, AL, 4'h0, 1'b0);
      #1;
      exp_rdy = SKID ? (occ < CAP) : (occ == 0 || rdy_in);
      if (bus.o_ready !== exp_rdy) begin $display("FAIL bp_drain_ready c=%0d got=%0b exp=%0b", c, bus.o_ready, exp_rdy); n_bad++; end n_cmp++;
      if (bus.o_valid !== (occ != 0)) begin $display("FAIL bp_drain_valid c=%0d got=%0b exp=%0b", c, bus.o_valid, occ != 0); n_bad++; end n_cmp++;
      if (occ != 0) begin
        if (bus.o_result !== q[0]) begin $display("FAIL bp_order c=%0d got=%h exp=%h", c, bus.o_result, q[0]); n_bad++; end n_cmp++;
        void'(q.pop_front());
        occ--;
        got++;
      end
      if (idx < 3 && exp_rdy) begin
        q.push_back(offers[idx]);
        idx++;
        occ++;
      end
      step();
    end
    if (got !== 3) begin $display("FAIL bp_drain_count got=%0d exp=3", got); n_bad++; end n_cmp++;
    drive(1'b0, 32'h0, 4'h0, 1'b0, AL, 4'h0, 1'b0);
    step();
  endtask

  task automatic test_flush();
    bus.i_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 32'h40 + c, 4'h0, 1'b0, AL, 4'hA, 1'b1);
      step();
    end
    if (bus.o_valid !== 1'b1) begin $display("FAIL flush_pre_valid got=%0b exp=1", bus.o_valid); n_bad++; end n_cmp++;
    drive(1'b1, 32'h99, 4'b1111, 1'b1, AL, 4'hA, 1'b1);
    bus.i_flush = 1'b1;
    bus.i_ready = 1'b1;
    #1;
    if (bus.o_ready !== 1'b0) begin $display("FAIL flush_ready got=%0b exp=0", bus.o_ready); n_bad++; end n_cmp++;
    step();
    bus.i_flush = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0, AL, 4'h0, 1'b0);
    #1;
    if (bus.o_valid !== 1'b0) begin $display("FAIL flush_valid got=%0b exp=0", bus.o_valid); n_bad++; end n_cmp++;
    if (bus.o_flags !== 4'b1001) begin $display("FAIL flush_flags got=%b exp=1001", bus.o_flags); n_bad++; end n_cmp++;
    if (bus.o_result !== 32'h0) begin $display("FAIL flush_result got=%h exp=0", bus.o_result); n_bad++; end n_cmp++;
    step();
  endtask

  task automatic test_async_reset();
    bus.i_ready = 1'b0;
    drive(1'b1, 32'h77, 4'b0110, 1'b1, AL, 4'hB, 1'b1);
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, AL, 4'h0, 1'b0);
    if (bus.o_flags !== 4'b0110) begin $display("FAIL ar_pre_flags got=%b exp=0110", bus.o_flags); n_bad++; end n_cmp++;
    #3;
    rst_n = 1'b0;
    #1;
    if (bus.o_valid !== 1'b0) begin $display("FAIL ar_valid got=%0b exp=0", bus.o_valid); n_bad++; end n_cmp++;
    if (bus.o_flags !== 4'h0) begin $display("FAIL ar_flags got=%b exp=0000", bus.o_flags); n_bad++; end n_cmp++;
    if (bus.o_result !== 32'h0) begin $display("FAIL ar_result got=%h exp=0", bus.o_result); n_bad++; end n_cmp++;
    if (bus.o_wr_en !== 1'b0) begin $display("FAIL ar_wr_en got=%0b exp=0", bus.o_wr_en); n_bad++; end n_cmp++;
    if (bus.o_ready !== 1'b0) begin $display("FAIL ar_ready got=%0b exp=0", bus.o_ready); n_bad++; end n_cmp++;
    step();
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    step();
    if (bus.o_valid !== 1'b0) begin $display("FAIL ar_post_valid got=%0b exp=0", bus.o_valid); n_bad++; end n_cmp++;
    drive(1'b1, 32'h55, 4'h0, 1'b0, AL, 4'h6, 1'b1);
    step();
    if (bus.o_result !== 32'h55) begin $display("FAIL ar_new_result got=%h exp=55", bus.o_result); n_bad++; end n_cmp++;
    if (bus.o_rd !== 4'h6) begin $display("FAIL ar_new_rd got=%h exp=6", bus.o_rd); n_bad++; end n_cmp++;
    drive(1'b0, 32'h0, 4'h0, 1'b0, AL, 4'h0, 1'b0);
    step();
    if (bus.o_valid !== 1'b0) begin $display("FAIL ar_end_valid got=%0b exp=0", bus.o_valid); n_bad++; end n_cmp++;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_conditions();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cond_flags_stage.md
COND_FLAGS_STAGE -- requirements
Module: cond_flags_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of buffer entries when STAGE_SKID_EN is defined (ignored otherwise).
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  upstream has an ALU result this cycle.
REQ-005 o_ready  output  1  stage can accept; transfer when i_valid && o_ready.
REQ-006 i_result  input  32  ALU o_result.
REQ-007 i_nzcv  input  4  ALU o_nzcv, bit3=N, bit2=Z, bit1=C, bit0=V.
REQ-008 i_set_flags  input  1  instruction's S bit.
REQ-009 i_cond  input  4  ARM condition field of the instruction.
REQ-010 i_rd  input  4  destination register index.
REQ-011 i_wr_en  input  1  instruction writes i_rd.
REQ-012 i_flush  input  1  discard all buffered entries.
REQ-013 o_valid  output  1  head entry presented downstream.
REQ-014 i_ready  input  1  downstream accepts; drain when o_valid && i_ready.
REQ-015 o_result  output  32  head entry result.
REQ-016 o_rd  output  4  head entry destination.
REQ-017 o_wr_en  output  1  head entry write enable, already gated by condition pass.
REQ-018 o_cond_pass  output  1  head entry condition result.
REQ-019 o_flags  output  4  architectural NZCV flags register.

Function
REQ-020 Condition SHALL be evaluated at acceptance against o_flags of that cycle: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; NV (1111) 0.
REQ-021 On acceptance with pass && i_set_flags, o_flags SHALL take i_nzcv at that clock edge, so the next accepted instruction sees the new flags (back-to-back dependence, no bubble).
REQ-022 On acceptance with fail, o_flags SHALL be unchanged and the stored entry SHALL have wr_en=0 and cond_pass=0; failed entries still flow downstream (o_valid asserted).
REQ-023 Stored wr_en SHALL equal i_wr_en && pass; result and rd stored unmodified.
REQ-024 Latency SHALL be one cycle: an entry accepted at edge k is visible on outputs after edge k when buffer was empty.
REQ-025 Entries SHALL leave in acceptance order (FIFO); occupancy counter width ceil(log2(DEPTH+1)).
REQ-026 o_ready SHALL be 0 when occupancy == DEPTH or i_flush is 1; otherwise 1 (no combinational path from i_ready in skid mode).
REQ-027 Simultaneous accept and drain SHALL keep occupancy constant; head advances, new entry appended.
REQ-028 Occupancy SHALL never exceed DEPTH nor underflow; drain with occupancy 0 impossible since o_valid=0.
REQ-029 i_flush SHALL empty the buffer at the next edge (o_valid=0 after), ignore any drain that cycle, and leave o_flags unchanged.
REQ-030 When o_valid=0, o_result, o_rd, o_wr_en, o_cond_pass SHALL be 0.

Reset
REQ-031 i_rst_n low SHALL immediately force occupancy 0, o_valid 0, o_flags 4'b0000, o_result 0, o_rd 0, o_wr_en 0, o_cond_pass 0, without waiting for i_clk.
REQ-032 o_ready SHALL be 0 while i_rst_n is low and 1 from the first cycle after release.
REQ-033 Reset mid-operation SHALL discard all buffered entries; no partial transfer completes.

Configuration
REQ-034 Macro STAGE_SKID_EN defined: DEPTH-entry buffer as above, full throughput with registered o_ready.
REQ-035 STAGE_SKID_EN undefined: single-entry register, DEPTH ignored, o_ready = !i_flush && (!o_valid || i_ready); all other requirements unchanged.

Verification
REQ-036 Reset, flags 0000; accept cond=AL, set_flags=1, nzcv=0100, result=0 -> next cycle o_valid=1, o_cond_pass=1, o_flags=0100.
REQ-037 Back-to-back: after flags Z=1, accept cond=EQ wr_en=1 then cond=NE wr_en=1 -> first o_wr_en=1, second o_wr_en=0, o_cond_pass=0, o_valid=1 for both.
REQ-038 cond=NV, set_flags=1, nzcv=1111 -> o_flags unchanged, o_wr_en=0; GE with N=1,V=1 -> pass; LT same flags -> fail.
REQ-039 Skid mode, i_ready=0, three offers result=0x11,0x22,0x33 -> o_ready 0 after two accepts; release i_ready -> outputs 0x11, 0x22, then 0x33 accepted, order preserved.
REQ-040 Two entries buffered, assert i_flush with i_valid=1 -> o_ready=0, next cycle o_valid=0, o_flags unchanged.
REQ-041 Assert i_rst_n=0 between clock edges with entries buffered -> outputs and o_flags 0 immediately; first post-reset output only from new acceptance.
